uart_tx_buf: RTL and testbench
==============================

UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 Parameter DEPTH, default 16 (power of 2, >=4); FIFO entries.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-004 ut_tx_data  in  8  byte pushed by user logic.
REQ-005 ut_tx_data_rdy  in  1  push strobe; one byte per high cycle.
REQ-006 erase  in  1  synchronous flush of FIFO and sequencer.
REQ-007 tx_busy  in  1  transmitter busy flag from buart.
REQ-008 tx_data  out  8  byte presented to buart; registered.
REQ-009 tx_data_rdy  out  1  one-cycle send strobe to buart; registered.
REQ-010 ut_full  out  1  FIFO holds DEPTH entries.
REQ-011 ut_empty  out  1  FIFO holds 0 entries.
REQ-012 ut_count  out  log2(DEPTH)+1  current FIFO occupancy.
REQ-013 ut_done  out  1  one-cycle pulse: last byte finished, FIFO empty, sequencer idle.

Function
REQ-014 FIFO: circular buffer, read/write pointers log2(DEPTH)+1 bits; wrap at DEPTH; full/empty from MSB compare.
REQ-015 Push while ut_full=1 shall be dropped; FIFO contents and count unchanged.
REQ-016 Simultaneous push and pop shall leave ut_count unchanged, including when full (pop frees slot same cycle) and when count=1.
REQ-017 Sequencer states: IDLE, SEND, WAIT_HI, WAIT_LO.
REQ-018 IDLE -> SEND when ut_empty=0 and tx_busy=0; pop head byte into tx_data register.
REQ-019 SEND: tx_data_rdy=1 for exactly one cycle; -> WAIT_HI.
REQ-020 WAIT_HI: hold until tx_busy=1, then -> WAIT_LO; tx_data stable.
REQ-021 WAIT_LO: on tx_busy=0 -> IDLE; if FIFO empty at that transition (and no pending CRLF byte) pulse ut_done next cycle.
REQ-022 Latency: byte pushed into empty FIFO with idle sequencer and tx_busy=0 appears with tx_data_rdy=1 three cycles after push edge (write, pop/IDLE->SEND, strobe).
REQ-023 tx_data_rdy shall never be asserted while tx_busy=1 or on two consecutive cycles.
REQ-024 erase: pointers and count cleared, sequencer -> IDLE, tx_data_rdy=0 next cycle; a byte already strobed is not recalled; push coincident with erase is discarded.
REQ-025 ut_count, ut_full, ut_empty reflect state after the current edge; combinational from registered pointers only.

Reset
REQ-026 reset=0 asynchronously: pointers=0, ut_count=0, ut_empty=1, ut_full=0, tx_data=8'h00, tx_data_rdy=0, ut_done=0, sequencer IDLE, CRLF pending flag 0.
REQ-027 Reset mid-transfer abandons the byte; no strobe issued in the cycle after reset release.
REQ-028 FIFO storage array need not be reset.

Configuration
REQ-029 Macro UART_TX_CRLF_EN: when defined, a popped 8'h0A is sent as 8'h0D then 8'h0A (two full SEND/WAIT_HI/WAIT_LO cycles, LF from internal pending flag, not FIFO); ut_done only after the LF.
REQ-030 Without UART_TX_CRLF_EN, all bytes including 8'h0A sent verbatim, no pending flag logic.
REQ-031 erase or reset clears CRLF pending flag in both builds.

Verification
REQ-032 Reset, push 8'h41 with tx_busy=0 -> tx_data=8'h41, tx_data_rdy=1 for one cycle 3 cycles later; model busy 10 cycles -> ut_done pulse after busy falls.
REQ-033 Push 17 bytes 8'h00..8'h10 back-to-back with tx_busy=1 held -> ut_full=1 after 16, byte 8'h10 dropped, ut_count=16; release busy -> 8'h00..8'h0F sent in order.
REQ-034 Fill FIFO, then push and pop same cycle -> ut_count stays 16, new byte sent last.
REQ-035 UART_TX_CRLF_EN defined, push 8'h0A -> strobes 8'h0D then 8'h0A, single ut_done; undefined -> single 8'h0A strobe.
REQ-036 Push 5 bytes, assert erase during WAIT_HI -> ut_empty=1, ut_count=0 next cycle, no further strobes; reset=0 mid-WAIT_LO -> all outputs at reset values immediately.

Source files
------------

// File: rtl/uart_tx_buf.sv
// Byte FIFO feeding a UART transmitter through a four-state send sequencer.
// Optional macro UART_TX_CRLF_EN expands each popped LF into a CR then LF.
module uart_tx_buf #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               ut_tx_data,
    input  logic                     ut_tx_data_rdy,
    input  logic                     erase,
    input  logic                     tx_busy,
    output logic [7:0]               tx_data,
    output logic                     tx_data_rdy,
    output logic                     ut_full,
    output logic                     ut_empty,
    output logic [$clog2(DEPTH):0]   ut_count,
    output logic                     ut_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [7:0]  LF = 8'h0A;
`ifdef UART_TX_CRLF_EN
    localparam logic [7:0]  CR = 8'h0D;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t      r_state;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_mem [DEPTH];
    logic [7:0]  r_tx_data;
    logic        r_tx_data_rdy;
    logic        r_done;
    logic [7:0]  w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_pend;

`ifdef UART_TX_CRLF_EN
    logic        r_crlf_pend;
    assign w_pend = r_crlf_pend;
`else
    assign w_pend = 1'b0;
`endif

    assign ut_empty    = (r_wr_ptr == r_rd_ptr);
    assign ut_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign ut_count    = r_wr_ptr - r_rd_ptr;
    assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
    assign tx_data     = r_tx_data;
    assign tx_data_rdy = r_tx_data_rdy;
    assign ut_done     = r_done;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
    assign w_pop  = (r_state == S_IDLE) && !ut_empty && !tx_busy && !erase && !w_pend;
    assign w_push = ut_tx_data_rdy && !erase && (!ut_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= ut_tx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (erase) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_tx_data     <= 8'h00;
            r_tx_data_rdy <= 1'b0;
            r_done        <= 1'b0;
`ifdef UART_TX_CRLF_EN
            r_crlf_pend   <= 1'b0;
`endif
        end else begin
            r_tx_data_rdy <= 1'b0;
            r_done        <= 1'b0;
            if (erase) begin
                r_state <= S_IDLE;
`ifdef UART_TX_CRLF_EN
                r_crlf_pend <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
`ifdef UART_TX_CRLF_EN
                        if (r_crlf_pend) begin
                            if (!tx_busy) begin
                                r_tx_data   <= LF;
                                r_crlf_pend <= 1'b0;
                                r_state     <= S_SEND;
                            end
                        end else
`endif
                        if (w_pop) begin
`ifdef UART_TX_CRLF_EN
                            if (w_head == LF) begin
                                r_tx_data   <= CR;
                                r_crlf_pend <= 1'b1;
                            end else begin
                                r_tx_data   <= w_head;
                            end
`else
                            r_tx_data <= w_head;
`endif
                            r_state <= S_SEND;
                        end
                    end
                    S_SEND: begin
                        // Never strobe into a transmitter that is still busy.
                        if (!tx_busy) begin
                            r_tx_data_rdy <= 1'b1;
                            r_state       <= S_WAIT_HI;
                        end
                    end
                    S_WAIT_HI: begin
                        if (tx_busy) r_state <= S_WAIT_LO;
                    end
                    S_WAIT_LO: begin
                        if (!tx_busy) begin
                            r_state <= S_IDLE;
                            if (ut_empty && !w_pend) r_done <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // LF is referenced only by the CRLF build; keep it visible in the default one.
    logic w_lf_unused;
    assign w_lf_unused = ^LF;
endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf with a behavioural busy model of the transmitter.
module tb_uart_tx_buf;
    localparam int DEPTH    = 16;
    localparam int BUSY_LEN = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ut_tx_data;
    logic       ut_tx_data_rdy;
    logic       erase;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_data_rdy;
    logic       ut_full;
    logic       ut_empty;
    logic [4:0] ut_count;
    logic       ut_done;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         viol     = 0;
    int         done_cnt = 0;
    logic       prev_rdy = 1'b0;

    logic model_busy;
    int   busy_cnt;
    logic hold_busy = 1'b0;

    assign tx_busy = model_busy | hold_busy;

    always #5 clk = ~clk;

    uart_tx_buf #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .ut_tx_data     (ut_tx_data),
        .ut_tx_data_rdy (ut_tx_data_rdy),
        .erase          (erase),
        .tx_busy        (tx_busy),
        .tx_data        (tx_data),
        .tx_data_rdy    (tx_data_rdy),
        .ut_full        (ut_full),
        .ut_empty       (ut_empty),
        .ut_count       (ut_count),
        .ut_done        (ut_done)
    );

    // Transmitter model: busy rises the edge after a strobe and stays high BUSY_LEN cycles.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_busy <= 1'b0;
            busy_cnt   <= 0;
        end else if (tx_data_rdy) begin
            model_busy <= 1'b1;
            busy_cnt   <= BUSY_LEN;
        end else if (busy_cnt > 0) begin
            busy_cnt   <= busy_cnt - 1;
            model_busy <= (busy_cnt > 1);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (tx_data_rdy) begin
                obs_q.push_back(tx_data);
                viol <= viol + (tx_busy ? 1 : 0) + (prev_rdy ? 1 : 0);
            end
            if (ut_done) done_cnt <= done_cnt + 1;
            prev_rdy <= tx_data_rdy;
        end else begin
            prev_rdy <= 1'b0;
        end
    end

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        ut_tx_data     = b;
        ut_tx_data_rdy = 1'b1;
        @(negedge clk);
        ut_tx_data_rdy = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int quiet;
        quiet = 0;
        ok    = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (ut_empty && !tx_busy && !tx_data_rdy) quiet++;
            else quiet = 0;
            if (quiet >= 6) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        ut_tx_data     = 8'h00;
        ut_tx_data_rdy = 1'b0;
        erase          = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        total++; if (tx_data_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b want 0", tx_data_rdy); end
        total++; if (ut_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", ut_done); end
        total++; if (ut_count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", ut_count); end
        total++; if (ut_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", ut_empty); end
        total++; if (ut_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", ut_full); end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int         d0;
        bit         ok;
        logic [7:0] e, o;
        d0 = done_cnt;
        @(negedge clk);
        ut_tx_data     = 8'h41;
        ut_tx_data_rdy = 1'b1;
        exp_q.push_back(8'h41);
        @(posedge clk); #1;
        ut_tx_data_rdy = 1'b0;
        total++; if (ut_count !== 5'd1) begin bad++; $display("FAIL single_count: got %0d want 1", ut_count); end
        @(posedge clk); #1;
        total++; if (tx_data_rdy !== 1'b0) begin bad++; $display("FAIL single_early_rdy: got %b want 0", tx_data_rdy); end
        total++; if (tx_data !== 8'h41) begin bad++; $display("FAIL single_data: got %h want 41", tx_data); end
        @(posedge clk); #1;
        total++; if (tx_data_rdy !== 1'b1) begin bad++; $display("FAIL single_latency: got %b want 1", tx_data_rdy); end
        @(posedge clk); #1;
        total++; if (tx_data_rdy !== 1'b0) begin bad++; $display("FAIL single_pulse_width: got %b want 0", tx_data_rdy); end
        wait_idle(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout: got busy want idle"); end
        repeat (3) @(negedge clk);
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL single_done: got %0d pulses want 1", done_cnt - d0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL single_sb: got nothing want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL single_sb: got %h want %h", o, e); end
            end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL single_extra: got %0d extra bytes want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_full();
        bit         ok;
        logic [7:0] e, o;
        @(negedge clk);
        hold_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 15) begin
                total++; if (ut_full !== 1'b0) begin bad++; $display("FAIL full_early: got %b want 0", ut_full); end
            end
            if (i == 16) begin
                total++; if (ut_full !== 1'b1) begin bad++; $display("FAIL full_flag: got %b want 1", ut_full); end
            end
            ut_tx_data     = 8'(i);
            ut_tx_data_rdy = 1'b1;
            if (i < 16) exp_q.push_back(8'(i));
        end
        @(negedge clk);
        ut_tx_data_rdy = 1'b0;
        total++; if (ut_count !== 5'd16) begin bad++; $display("FAIL full_drop_count: got %0d want 16", ut_count); end
        total++; if (ut_full !== 1'b1) begin bad++; $display("FAIL full_after_drop: got %b want 1", ut_full); end
        hold_busy = 1'b0;
        wait_idle(800, ok);
        total++; if (!ok) begin bad++; $display("FAIL full_timeout: got busy want idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL full_sb: got nothing want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL full_sb: got %h want %h", o, e); end
            end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL full_extra: got %0d extra bytes want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_simul();
        bit         ok;
        logic [7:0] e, o;
        @(negedge clk);
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ut_tx_data     = 8'h20 + 8'(i);
            ut_tx_data_rdy = 1'b1;
            exp_q.push_back(8'h20 + 8'(i));
        end
        @(negedge clk);
        total++; if (ut_full !== 1'b1) begin bad++; $display("FAIL simul_fill: got %b want 1", ut_full); end
        ut_tx_data = 8'h30;
        hold_busy  = 1'b0;
        exp_q.push_back(8'h30);
        @(posedge clk); #1;
        ut_tx_data_rdy = 1'b0;
        total++; if (ut_count !== 5'd16) begin bad++; $display("FAIL simul_count: got %0d want 16", ut_count); end
        wait_idle(800, ok);
        total++; if (!ok) begin bad++; $display("FAIL simul_timeout: got busy want idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL simul_sb: got nothing want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL simul_sb: got %h want %h", o, e); end
            end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL simul_extra: got %0d extra bytes want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_crlf();
        int         d0;
        bit         ok;
        logic [7:0] e, o;
        d0 = done_cnt;
        push_byte(8'h0A);
`ifdef UART_TX_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL crlf_timeout: got busy want idle"); end
        repeat (3) @(negedge clk);
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL crlf_done: got %0d pulses want 1", done_cnt - d0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL crlf_sb: got nothing want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL crlf_sb: got %h want %h", o, e); end
            end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL crlf_extra: got %0d extra bytes want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_erase();
        bit         ok;
        logic [7:0] e, o;
        @(negedge clk);
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ut_tx_data     = 8'h50 + 8'(i);
            ut_tx_data_rdy = 1'b1;
        end
        @(negedge clk);
        ut_tx_data_rdy = 1'b0;
        hold_busy      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        total++; if (tx_data_rdy !== 1'b1 || tx_data !== 8'h50) begin bad++; $display("FAIL erase_first_strobe: got %b/%h want 1/50", tx_data_rdy, tx_data); end
        exp_q.push_back(8'h50);
        erase = 1'b1;
        @(posedge clk); #1;
        erase = 1'b0;
        total++; if (ut_empty !== 1'b1) begin bad++; $display("FAIL erase_empty: got %b want 1", ut_empty); end
        total++; if (ut_count !== 5'd0) begin bad++; $display("FAIL erase_count: got %0d want 0", ut_count); end
        total++; if (tx_data_rdy !== 1'b0) begin bad++; $display("FAIL erase_rdy: got %b want 0", tx_data_rdy); end
        repeat (60) @(negedge clk);
        wait_idle(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL erase_timeout: got busy want idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL erase_sb: got nothing want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL erase_sb: got %h want %h", o, e); end
            end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL erase_extra: got %0d extra bytes want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        bit         seen;
        logic [7:0] e, o;
        push_byte(8'h60);
        push_byte(8'h61);
        exp_q.push_back(8'h60);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (tx_busy) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL rstmid_busy_timeout: got idle want busy"); end
        @(posedge clk);
        @(negedge clk);
        total++; if (ut_count !== 5'd1) begin bad++; $display("FAIL rstmid_pre_count: got %0d want 1", ut_count); end
        reset = 1'b0;
        #1;
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rstmid_tx_data: got %h want 00", tx_data); end
        total++; if (tx_data_rdy !== 1'b0) begin bad++; $display("FAIL rstmid_rdy: got %b want 0", tx_data_rdy); end
        total++; if (ut_count !== 5'd0 || ut_empty !== 1'b1 || ut_full !== 1'b0) begin bad++; $display("FAIL rstmid_fifo: got cnt=%0d e=%b f=%b want 0/1/0", ut_count, ut_empty, ut_full); end
        total++; if (ut_done !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", ut_done); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (tx_data_rdy !== 1'b0) begin bad++; $display("FAIL rstmid_release1: got %b want 0", tx_data_rdy); end
        @(posedge clk); #1;
        total++; if (tx_data_rdy !== 1'b0) begin bad++; $display("FAIL rstmid_release2: got %b want 0", tx_data_rdy); end
        repeat (30) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL rstmid_sb: got nothing want %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL rstmid_sb: got %h want %h", o, e); end
            end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rstmid_extra: got %0d extra bytes want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_simul();
        test_crlf();
        test_erase();
        test_reset_mid();
        total++; if (viol != 0) begin bad++; $display("FAIL strobe_protocol: got %0d violations want 0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
